// File: rtl/fns_enc_25_seq_if.sv
// Handshake bundle for the Fibonacci encoder: an input word channel and a
// result channel carrying the 25-digit codeword and the range-error flag.

`ifndef FBLEN25
`define FBLEN25 19
`endif

interface fns_enc_25_seq_if #(
  parameter int DW = `FBLEN25
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [24:0]   codeout;
  logic          err;

  // Producer/consumer side: drives words in and takes results out.
  modport master (
    output in_valid, datain, out_ready,
    input  in_ready, out_valid, codeout, err
  );

  // Encoder side.
  modport slave (
    input  in_valid, datain, out_ready,
    output in_ready, out_valid, codeout, err
  );
endinterface

// File: rtl/fns_enc_25_seq.sv
// Sequential binary-to-Fibonacci encoder. One greedy digit is resolved per
// clock from the most significant weight down, so every in-range word takes
// the same 25 cycles regardless of its value. Weights are 1, 2, 3, 5, 8, ...
// (bit 0 = 1, bit 1 = 2, each further weight the sum of the two below it).

`ifndef FBLEN25
`define FBLEN25 19
`endif

module fns_enc_25_seq #(
  parameter int NDIG = 25,
  parameter int DW   = `FBLEN25
) (
  input  logic            clk,
  input  logic            rst_n,
  fns_enc_25_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         WW      = DW + 1;
  localparam logic [4:0] IDX_TOP = 5'(NDIG - 1);

  // Packed table of the digit weights, each WW bits wide, weight of digit k
  // at slice k. Built at elaboration time so the datapath only indexes it.
  function automatic logic [NDIG*WW-1:0] build_weights();
    logic [NDIG*WW-1:0] tab;
    logic [WW-1:0]      a;
    logic [WW-1:0]      b;
    logic [WW-1:0]      c;
    tab = '0;
    a   = WW'(1);
    b   = WW'(2);
    for (int k = 0; k < NDIG; k++) begin
      tab[k*WW +: WW] = a;
      c = a + b;
      a = b;
      b = c;
    end
    return tab;
  endfunction

  // Largest encodable value: every digit set.
  function automatic logic [WW-1:0] sum_weights(input logic [NDIG*WW-1:0] tab);
    logic [WW-1:0] s;
    s = '0;
    for (int k = 0; k < NDIG; k++) begin
      s = s + tab[k*WW +: WW];
    end
    return s;
  endfunction

  localparam logic [NDIG*WW-1:0] WEIGHTS = build_weights();
  localparam logic [WW-1:0]      MAXV    = sum_weights(WEIGHTS);

  state_t        state_q, state_d;
  logic [4:0]    idx_q,   idx_d;
  logic [DW-1:0] rem_q,   rem_d;
  logic [24:0]   code_q,  code_d;
  logic          err_q,   err_d;
  logic [WW-1:0] w_cur;
  logic          take_digit;

  // Weight of the digit currently being resolved and the greedy decision.
  always_comb begin
    w_cur      = WEIGHTS[int'(idx_q)*WW +: WW];
    take_digit = ({1'b0, rem_q} >= w_cur);
  end

  // Next-state and datapath update: accept in IDLE, one digit per cycle in
  // CONV, hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          code_d = '0;
          if ({1'b0, bus.datain} > MAXV) begin
            // Out-of-range words skip conversion entirely.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            rem_d   = bus.datain;
            idx_d   = IDX_TOP;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        if (take_digit) begin
          code_d[idx_q] = 1'b1;
          rem_d         = rem_q - w_cur[DW-1:0];
        end else begin
          code_d[idx_q] = 1'b0;
        end
        if (idx_q == 5'd0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      rem_q   <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.codeout   = code_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fns_enc_25_seq.sv
// Bench for the Fibonacci encoder: a driver issues words and pushes the
// model's expected result into a queue; an independent monitor pops and
// compares on every result handshake.

module tb_fns_enc_25_seq;

  localparam int DW   = 19;
  localparam int NDIG = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fns_enc_25_seq_if #(.DW(DW)) bus ();

  fns_enc_25_seq #(.NDIG(NDIG), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint unsigned data;
    logic [24:0]     code;
    logic            err;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              pushed = 0;
  int              popped = 0;
  longint unsigned w[NDIG];
  longint unsigned maxv;

  // Fibonacci weights 1, 2, 3, 5, ... and their total.
  function automatic void build_model();
    w[0] = 1;
    w[1] = 2;
    for (int k = 2; k < NDIG; k++) w[k] = w[k-1] + w[k-2];
    maxv = 0;
    for (int k = 0; k < NDIG; k++) maxv += w[k];
  endfunction

  // Greedy representation from the largest weight down.
  function automatic exp_t model(input longint unsigned v);
    exp_t            r;
    longint unsigned rem;
    r.data = v;
    r.code = '0;
    r.err  = 1'b0;
    if (v > maxv) begin
      r.err = 1'b1;
    end else begin
      rem = v;
      for (int k = NDIG - 1; k >= 0; k--) begin
        if (rem >= w[k]) begin
          r.code[k] = 1'b1;
          rem       = rem - w[k];
        end
      end
    end
    return r;
  endfunction

  function automatic longint unsigned decode(input logic [24:0] c);
    longint unsigned s = 0;
    for (int k = 0; k < NDIG; k++) if (c[k]) s += w[k];
    return s;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a result is consumed at the posedge following a negedge where
  // out_valid and out_ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", bus.codeout);
        end else begin
          e = sbq.pop_front();
          popped++;
          chk("sb_code", bus.codeout, e.code);
          chk("sb_err", bus.err, e.err);
          if (!e.err) chk("sb_decode", decode(bus.codeout), e.data);
        end
      end
    end
  end

  // Issue one word, verify latency, optionally stall the result and keep
  // in_valid asserted with junk data while busy. Called at posedge+1.
  task automatic send(input longint unsigned d, input int stall, input bit junk);
    exp_t        e;
    int          n;
    logic [24:0] code_h;
    logic        err_h;
    bus.datain   = DW'(d);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(d);
    @(posedge clk);
    sbq.push_back(e);
    pushed++;
    #1;
    bus.in_valid = junk;
    if (junk) bus.datain = DW'($urandom);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, e.err ? 0 : 25);
    code_h = bus.codeout;
    err_h  = bus.err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (junk) bus.datain = DW'($urandom);
      chk("hold_code", bus.codeout, code_h);
      chk("hold_err", bus.err, err_h);
      chk("hold_busy", {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("ready_after", {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  // Reset during conversion: nothing may come out for the aborted word.
  task automatic reset_mid_conv(input longint unsigned d);
    bit seen;
    chk("rst_pre_idle", bus.in_ready, 1);
    bus.datain   = DW'(d);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async", {bus.in_ready, bus.out_valid, bus.err}, 3'b100);
    chk("rst_code", bus.codeout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_no_valid", seen, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint unsigned v;
    build_model();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.datain    = '0;
    #1;
    chk("reset_flags", {bus.in_ready, bus.out_valid, bus.err}, 3'b100);
    chk("reset_code", bus.codeout, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(0, 0, 1'b0);
    send(w[NDIG-1], 0, 1'b0);
    send(maxv, 2, 1'b0);
    send(maxv + 1, 1, 1'b0);
    send((longint'(1) << DW) - 1, 0, 1'b0);
    send(12345, 10, 1'b1);
    send(maxv + 7, 10, 1'b1);
    reset_mid_conv(54321);
    send(54321, 0, 1'b0);
    send(w[0], 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      v = longint'($urandom_range(0, 32'(maxv)));
      send(v, int'($urandom_range(0, 3)), 1'(($urandom % 4) == 0));
    end
    for (int i = 0; i < 20; i++) begin
      v = longint'($urandom_range(32'(maxv + 1), (32'd1 << DW) - 1));
      send(v, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    chk("sb_count", popped, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
